// File: rtl/rr_lane_arbiter_pkg.sv
// Shared definitions for the round-robin lane arbiter and its lane mux.
package rr_lane_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_lane_arbiter_pick.sv
// Rotating-priority picker: first requester at or after base, wrapping mod N.
module rr_pick
  import rr_lane_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] base,
  output logic          any,
  output logic [SW-1:0] idx
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] masked;

  // Window [base, base+N) over the doubled vector gives the wrap-around scan order.
  always_comb begin
    req_dbl = {req, req};
    masked  = '0;
    for (int i = 0; i < 2*N; i++) begin
      if (i >= int'(base) && i < int'(base) + N) masked[i] = req_dbl[i];
    end
  end

  always_comb begin
    any = |req;
    idx = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (masked[i]) idx = (i >= N) ? SW'(i - N) : SW'(i);
    end
  end

endmodule

// File: rtl/rr_lane_arbiter.sv
// Round-robin N:1 lane arbiter with burst lock, stall timeout and valid/ready output.
module rr_lane_arbiter
  import rr_lane_arbiter_pkg::*;
#(
  parameter int N       = 4,
  parameter int M       = 8,
  parameter int TIMEOUT = 16,
  localparam int SW     = clog2(N)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N-1:0]    i_req,
  input  logic [N-1:0]    i_last,
  input  logic [N*M-1:0]  i_data,
  output logic [N-1:0]    o_ack,
  output logic [N-1:0]    o_gnt,
  output logic [SW-1:0]   o_sel,
  output logic            o_valid,
  output logic [M-1:0]    o_data,
  input  logic            i_ready,
  output logic            o_timeout
);

  localparam int CW = clog2(TIMEOUT) + 1;

  state_t         state;
  logic [SW-1:0]  ptr;
  logic [CW-1:0]  stall_cnt;

  logic           pick_any;
  logic [SW-1:0]  pick_idx;
  logic           locked;
  logic           xfer;
  logic           timeout_hit;
  logic [SW-1:0]  next_ptr;

  rr_pick #(.N(N), .SW(SW)) u_pick (
    .req  (i_req),
    .base (ptr),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  assign locked      = (state == ST_LOCK);
  assign o_valid     = locked & i_req[o_sel];
  assign o_data      = i_data[o_sel*M +: M];
  assign xfer        = o_valid & i_ready;
  assign o_ack       = xfer ? o_gnt : '0;
  assign timeout_hit = locked & ~xfer & (stall_cnt == CW'(TIMEOUT - 1));
  assign next_ptr    = (o_sel == SW'(N - 1)) ? '0 : o_sel + SW'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      stall_cnt <= '0;
      o_gnt     <= '0;
      o_sel     <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      if (state == ST_IDLE) begin
        o_gnt <= '0;
        if (pick_any) begin
          o_sel     <= pick_idx;
          o_gnt     <= N'(1) << pick_idx;
          state     <= ST_LOCK;
          stall_cnt <= '0;
        end
      end else if (xfer) begin
        stall_cnt <= '0;
        if (i_last[o_sel]) begin
          state <= ST_IDLE;
          ptr   <= next_ptr;
          o_gnt <= '0;
        end
      end else if (timeout_hit) begin
        // Forced release; the stalled requester goes to the back of the rotation.
        state     <= ST_IDLE;
        ptr       <= next_ptr;
        o_gnt     <= '0;
        o_timeout <= 1'b1;
        stall_cnt <= '0;
      end else begin
        stall_cnt <= stall_cnt + CW'(1);
      end
    end
  end

endmodule
